// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: serial-unit state encoding and
// the sizing helper for the bit counters.
package arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Width of a counter that must reach width-1; never narrower than one bit.
  function automatic int count_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/one_bit_full_subtractor.sv
// Combinational 1-bit full subtractor: d = x - y - bin, bout set on underflow.
module one_bit_full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor, LSB first, valid/ready on both sides.
// Optional signed overflow output when SERIAL_SUB_OVERFLOW_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | in_ready=1, waiting for operands
// RUN     | one difference bit per edge, WIDTH edges total
// DONE    | out_valid=1, result held until out_ready
module serial_full_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] difference,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             borrow_out
);

  localparam int COUNT_W = count_w(WIDTH);
  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   res_sr;
  logic [WIDTH-1:0]   res_next;
  logic               brw;
  logic [COUNT_W-1:0] count;
  logic               cell_d;
  logic               cell_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic               a_msb;
`endif

  one_bit_full_subtractor u_cell (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (brw),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Shift the new bit in at the MSB; written this way so WIDTH=1 needs no slice.
  always_comb begin
    res_next = res_sr >> 1;
    res_next[WIDTH-1] = cell_d;
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      brw        <= 1'b0;
      count      <= '0;
      difference <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb      <= 1'b0;
      overflow   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= borrow_in;
            count <= '0;
            state <= ST_RUN;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb <= a[WIDTH-1];
`endif
          end
        end
        ST_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          brw    <= cell_bout;
          res_sr <= res_next;
          count  <= count + COUNT_W'(1);
          // Outputs only update on the final edge, so an aborted job never leaks.
          if (count == LAST) begin
            state      <= ST_DONE;
            difference <= res_next;
            borrow_out <= cell_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // On the last edge the cell is processing the operand MSBs.
            overflow   <= (a_sr[0] ^ b_sr[0]) & (cell_d ^ a_msb);
`endif
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
